// File: rtl/c157x_pkg.sv
// ---------------------------------------------------------------------------
// c157x_pkg
// Shared types and constants for the 157x track-cache sequencer.
//   trk_state_t : sequencer states (idle, settle, flush, load)
//   SLOT_W      : width of a track slot index (side * per_side + half-track)
//   LBA_W       : width of an SD block address
//   slot_of()   : live slot index from side and half-track
// ---------------------------------------------------------------------------
package c157x_pkg;

    localparam int SLOT_W = 8;
    localparam int LBA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_LOAD   = 2'd3
    } trk_state_t;

    // Side 1 slots follow all side 0 slots in the image.
    function automatic logic [SLOT_W-1:0] slot_of(input logic       side,
                                                  input logic [6:0] htrack,
                                                  input int         per_side);
        return side ? SLOT_W'(per_side) + SLOT_W'(htrack) : SLOT_W'(htrack);
    endfunction

endpackage

// File: rtl/c157x_track_ctl.sv
// ---------------------------------------------------------------------------
// c157x_track_ctl
// Track-cache sequencer for the 157x drive. Watches half-track and side,
// waits for the head position to settle, writes a dirty track buffer back to
// the SD image and then reads the newly selected track. While a transfer runs
// the buffer belongs to the SD side and sd_busy holds the head block off.
//
// Ports
//   clk, reset_n      : drive clock, synchronous active-low reset
//   ce                : drive clock enable, paces the settle counter only
//   img_mounted       : image present (level)
//   img_readonly      : image write-protected, suppresses write-back
//   htrack, side      : live head position from the stepper
//   sd_update         : head block wrote a buffer byte (pulse)
//   sd_lba            : first SD block of the track being transferred
//   sd_blk_cnt        : blocks per track minus one (constant)
//   sd_rd, sd_wr      : SD read / write requests (never both high)
//   sd_ack            : SD side transferring
//   sd_busy           : buffer owned by SD (flush or load in progress)
//   dirty             : buffer differs from the image
// ---------------------------------------------------------------------------
module c157x_track_ctl
    import c157x_pkg::*;
#(
    parameter int          TRK_BLKS     = 32,
    parameter int          TRK_PER_SIDE = 84,
    parameter logic [15:0] SETTLE       = 16'd12000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             img_mounted,
    input  logic             img_readonly,
    input  logic [6:0]       htrack,
    input  logic             side,
    input  logic             sd_update,
    output logic [LBA_W-1:0] sd_lba,
    output logic [5:0]       sd_blk_cnt,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    output logic             sd_busy,
    output logic             dirty
);

    trk_state_t        state_q, state_d;
    logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
    logic              cur_valid_q, cur_valid_d;
    logic [SLOT_W-1:0] tgt_slot_q, tgt_slot_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              dirty_q, dirty_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [LBA_W-1:0]  lba_q, lba_d;
    // Set once the current transfer's ack has been seen high.
    logic              ack_seen_q, ack_seen_d;
    // Masks an ack left over from an aborted transfer until it goes low.
    logic              ack_block_q, ack_block_d;

    logic [SLOT_W-1:0] slot_live;
    logic              ack_eff;
    logic              upd_ok;

    // A constant multiplier; reduces to a shift for power-of-two TRK_BLKS.
    function automatic logic [LBA_W-1:0] lba_of(input logic [SLOT_W-1:0] slot);
        return LBA_W'(slot) * LBA_W'(TRK_BLKS);
    endfunction

    assign slot_live = slot_of(side, htrack, TRK_PER_SIDE);
    assign ack_eff   = sd_ack && !ack_block_q;
    // Buffer writes only count while the head owns the buffer.
    assign upd_ok    = sd_update && cur_valid_q && !img_readonly &&
                       (state_q == ST_IDLE || state_q == ST_SETTLE);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // this block leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        cur_slot_d  = cur_slot_q;
        cur_valid_d = cur_valid_q;
        tgt_slot_d  = tgt_slot_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        lba_d       = lba_q;
        ack_seen_d  = ack_seen_q;
        ack_block_d = ack_block_q && sd_ack;
        dirty_d     = dirty_q || upd_ok;

        if (!img_mounted) begin
            // Unmount aborts everything; any ack still high belongs to the
            // aborted transfer.
            state_d     = ST_IDLE;
            rd_d        = 1'b0;
            wr_d        = 1'b0;
            cur_valid_d = 1'b0;
            dirty_d     = 1'b0;
            ack_seen_d  = 1'b0;
            ack_block_d = sd_ack;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!cur_valid_q || slot_live != cur_slot_q) begin
                        state_d    = ST_SETTLE;
                        tgt_slot_d = slot_live;
                        cnt_d      = SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (slot_live != tgt_slot_q) begin
                        tgt_slot_d = slot_live;
                        cnt_d      = SETTLE;
                    end else if (cnt_q == 16'd0) begin
                        ack_seen_d = 1'b0;
                        // dirty_d includes an update arriving this very cycle,
                        // so that byte rides along with the flush.
                        if (dirty_d && cur_valid_q && !img_readonly) begin
                            state_d = ST_FLUSH;
                            wr_d    = 1'b1;
                            lba_d   = lba_of(cur_slot_q);
                        end else begin
                            state_d = ST_LOAD;
                            rd_d    = 1'b1;
                            lba_d   = lba_of(tgt_slot_q);
                        end
                    end else if (ce) begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_FLUSH: begin
                    if (!ack_seen_q) begin
                        if (ack_eff) begin
                            ack_seen_d = 1'b1;
                            wr_d       = 1'b0;
                            dirty_d    = 1'b0;
                        end
                    end else if (!sd_ack) begin
                        state_d    = ST_LOAD;
                        rd_d       = 1'b1;
                        lba_d      = lba_of(tgt_slot_q);
                        ack_seen_d = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!ack_seen_q) begin
                        if (ack_eff) begin
                            ack_seen_d = 1'b1;
                            rd_d       = 1'b0;
                        end
                    end else if (!sd_ack) begin
                        // A head that moved on during the load is picked up
                        // by IDLE on the next cycle.
                        state_d     = ST_IDLE;
                        cur_slot_d  = tgt_slot_q;
                        cur_valid_d = 1'b1;
                        dirty_d     = 1'b0;
                        ack_seen_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values computed above.
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cur_slot_q  <= '0;
            cur_valid_q <= 1'b0;
            tgt_slot_q  <= '0;
            cnt_q       <= '0;
            dirty_q     <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            lba_q       <= '0;
            ack_seen_q  <= 1'b0;
            ack_block_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_slot_q  <= cur_slot_d;
            cur_valid_q <= cur_valid_d;
            tgt_slot_q  <= tgt_slot_d;
            cnt_q       <= cnt_d;
            dirty_q     <= dirty_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            lba_q       <= lba_d;
            ack_seen_q  <= ack_seen_d;
            ack_block_q <= ack_block_d;
        end
    end

    // Requests are dropped the moment the image goes away, not an edge later.
    assign sd_rd      = rd_q && img_mounted;
    assign sd_wr      = wr_q && img_mounted;
    assign sd_busy    = (state_q == ST_FLUSH) || (state_q == ST_LOAD);
    assign sd_lba     = lba_q;
    assign dirty      = dirty_q;
    assign sd_blk_cnt = 6'(TRK_BLKS - 1);

endmodule

// File: doc/c157x_track_ctl.md
# c157x_track_ctl

Track-cache sequencer for the 157x drive. It watches the stepper half-track and side, and writes a dirty track buffer back to the SD image. It then reads the new track image and holds the head-signal block off with `sd_busy` while each transfer runs. It sits between the drive CPU/stepper logic, the SD block-transfer interface and the head block's track buffer.

## Interface
- `TRK_BLKS`, default 32: 512-byte SD blocks per track image; 16 KB covers a 14-bit buffer.
- `TRK_PER_SIDE`, default 84: half-track slots per side in the image.
- `SETTLE`, default 16'd12000: `ce` ticks the half-track/side must stay stable before a swap.

Ports:
- `clk` in 1: drive clock.
- `reset_n` in 1: synchronous reset, active-low.
- `ce` in 1: drive clock enable. Only the settle counter uses it.
- `img_mounted` in 1: level, image present.
- `img_readonly` in 1: level, suppresses write-back.
- `htrack` in 7: current half-track from the stepper, 0..83.
- `side` in 1: head select, 0/1.
- `sd_update` in 1: pulse from the head block when a buffer byte is written.
- `sd_lba` out 32: first block of the requested track.
- `sd_blk_cnt` out 6: `TRK_BLKS`-1.
- `sd_rd` out 1: read request.
- `sd_wr` out 1: write request.
- `sd_ack` in 1: high while the SD side is transferring.
- `sd_busy` out 1: buffer owned by SD; drives the head block's `sd_busy`.
- `dirty` out 1: buffer differs from the image.

## Operation
- Slot index = `side`*`TRK_PER_SIDE` + `htrack`, 8 bits.
- `sd_lba` = slot*`TRK_BLKS`, zero-extended to 32 bits.
  - The address is computed from the latched target slot for loads and from the loaded slot for flushes.
  - It is registered and stable while any request is high.
- Registers:
  - `cur_slot`: slot currently held in the buffer.
  - `cur_valid`.
  - `tgt_slot`.
  - settle counter, 16 bits, saturating at 0.
- States:
  - IDLE. Go to SETTLE when `img_mounted` && (!`cur_valid` || slot ≠ `cur_slot`); `tgt_slot` ← slot, counter ← `SETTLE`.
  - SETTLE. If the slot changes, reload the counter and `tgt_slot`. Decrement on `ce`. At 0: go to FLUSH if `dirty` && `cur_valid` && !`img_readonly`, otherwise go to LOAD.
  - FLUSH. Raise `sd_wr` with `sd_lba` from `cur_slot`. When `sd_ack` rises, drop `sd_wr` and clear `dirty`. When `sd_ack` falls, go to LOAD.
  - LOAD. Raise `sd_rd` with `sd_lba` from `tgt_slot`. When `sd_ack` rises, drop `sd_rd`. When `sd_ack` falls, set `cur_slot` ← `tgt_slot` and `cur_valid` ← 1, then go to IDLE. If the live slot ≠ `tgt_slot` at that point, IDLE re-triggers on the next cycle.
- `sd_busy` = 1 in FLUSH and LOAD, 0 in IDLE and SETTLE. The head keeps spinning during settle.
- `dirty` is set by `sd_update` when `cur_valid` && !`img_readonly` && state ∈ {IDLE, SETTLE}. Updates in other states are ignored.
- `img_mounted` falling:
  - In any state, go to IDLE next cycle.
  - Clear `cur_valid` and `dirty`.
  - Drop `sd_rd`/`sd_wr` immediately.
  - An in-flight `sd_ack` is ignored until it falls.
- `img_mounted` rising: `cur_valid` is 0, so a fresh load happens after settle.
- At most one of `sd_rd`/`sd_wr` is high at any time.

## Timing
- Reset (`reset_n`=0 at a `clk` edge): state IDLE; outputs 0 (`sd_rd`, `sd_wr`, `sd_busy`, `dirty`, `sd_lba`); `cur_valid` 0.
- `sd_blk_cnt` is constant.
- Reset mid-transfer aborts; later `sd_ack` activity is ignored until `sd_ack` is low.
- The IDLE→SETTLE decision is made in the cycle the condition is first seen.
- SETTLE exits in the cycle after the `ce` that makes the counter reach 0.
- The `sd_rd`/`sd_wr` request is registered high in the first cycle of FLUSH/LOAD. It stays high until the first cycle `sd_ack`=1 is sampled, and falls in the following cycle.
- Completion is taken from `sd_ack` sampled 1 then 0. Minimum FLUSH or LOAD is 3 cycles.
- `sd_update` coinciding with SETTLE→FLUSH: the update is counted, and `dirty` is then cleared by the flush it joins.

## Structure
- A shared package `c157x_pkg` holds:
  - the state enum `trk_state_t` (IDLE, SETTLE, FLUSH, LOAD);
  - the slot width constant, 8;
  - the LBA width constant, 32.
- No sub-module; the slot-to-LBA multiply is a shift when `TRK_BLKS` is a power of 2.

## Test plan
- Mount, `htrack`=36, `side`=0, `SETTLE`=4 → after 4 `ce` ticks, `sd_rd`=1 with `sd_lba`=1152 and `sd_busy`=1. Ack pulse → `cur_slot`=36, `sd_busy`=0.
- Loaded slot 36: 3 `sd_update` pulses, then step to 38 → FLUSH with `sd_wr`, `sd_lba`=1152, `dirty` clears on ack. Then LOAD with `sd_lba`=1216.
- Same as the previous scenario with `img_readonly`=1 → no `sd_wr`, `dirty` stays 0, direct LOAD of 1216.
- Step 36→37→38 within settle → counter restarts. Exactly one LOAD at slot 38; `sd_lba` never equals 1184.
- `side`=1, `htrack`=2 → slot 86, `sd_lba`=2752.
- Unmount while `sd_ack`=1 in LOAD → `sd_rd`=0 and `sd_busy`=0 next cycle. `cur_valid`=0; no load until remount.
